window_line_buffer: RTL and testbench
=====================================

WINDOW_LINE_BUFFER -- requirements
Module: window_line_buffer

Interface
REQ-001 Parameter IMAGE_WIDTH, default 512: pixels per image line and buffer depth; SHALL be >= KERNEL_WIDTH.
REQ-002 Parameter IW_BIT_NUM, default 9: pointer width; SHALL satisfy 2**IW_BIT_NUM >= IMAGE_WIDTH.
REQ-003 Parameter PIXEL_WIDTH, default 8: bits per pixel.
REQ-004 Parameter KERNEL_WIDTH, default 3: pixels per output window, legal range 2..8.
REQ-005 Parameter EDGE_MODE, default 0: window positions past the line end; 0 = zero pad, 1 = replicate the last pixel.
REQ-006 clk  input  1  rising-edge clock; the only clock.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 data_in_pixel  input  PIXEL_WIDTH  write pixel.
REQ-009 data_in_valid  input  1  write request.
REQ-010 data_in_ready  output  1  buffer accepts a write this cycle.
REQ-011 data_out_window  output  KERNEL_WIDTH*PIXEL_WIDTH  window; pixel at column c+0 in the MSBs, c+KERNEL_WIDTH-1 in the LSBs.
REQ-012 data_out_valid  output  1  window is valid.
REQ-013 data_out_read  input  1  consume the current window and advance one column.
REQ-014 line_done  output  1  one-cycle pulse on consumption of the last column.
REQ-015 fill_count  output  IW_BIT_NUM+1  pixels written into the current line.

Function
REQ-016 The block SHALL implement two states: FILL and DRAIN.
REQ-017 In FILL: data_in_ready=1, data_out_valid=0; a write fires on data_in_valid, storing data_in_pixel at write pointer wp, incrementing wp and fill_count.
REQ-018 The write that makes fill_count reach IMAGE_WIDTH SHALL move the state to DRAIN on the next edge; data_out_valid=1 in the cycle after that write (1-cycle latency).
REQ-019 In DRAIN: data_in_ready=0; data_in_valid SHALL be ignored (no memory write, no pointer or count change).
REQ-020 In DRAIN, data_out_window SHALL be combinationally derived from stored pixels and read column rc; no additional latency.
REQ-021 Window element i (0..KERNEL_WIDTH-1) SHALL be buf[rc+i] when rc+i <= IMAGE_WIDTH-1; otherwise 0 (EDGE_MODE=0) or buf[IMAGE_WIDTH-1] (EDGE_MODE=1); no wrap to column 0.
REQ-022 A read fires when data_out_read=1 and data_out_valid=1; rc increments by 1; rc SHALL hold when no read fires.
REQ-023 data_out_read while data_out_valid=0 SHALL be ignored.
REQ-024 A read at rc=IMAGE_WIDTH-1 SHALL assert line_done for exactly that cycle (combinational with the firing read), clear rc, wp and fill_count to 0, and return to FILL on the next edge.
REQ-025 Pointer arithmetic SHALL be sized to IW_BIT_NUM+1 bits internally for the edge comparison; no overflow for non-power-of-2 IMAGE_WIDTH.
REQ-026 Stored pixels SHALL remain unchanged during DRAIN.

Reset
REQ-027 On reset=1 at a rising edge: state=FILL, wp=0, rc=0, fill_count=0; hence data_in_ready=1, data_out_valid=0, line_done=0.
REQ-028 Reset SHALL take priority over simultaneous writes and reads in the same cycle; memory contents are not cleared.
REQ-029 Reset mid-FILL or mid-DRAIN SHALL discard the partial line; the next accepted pixel lands at column 0.

Verification
REQ-030 IMAGE_WIDTH=8, K=3: write pixels 1..8 back-to-back -> data_out_valid=1 the cycle after pixel 8, window=0x010203, data_in_ready=0.
REQ-031 Same line, read every cycle -> windows 010203, 020304 ... 060708, 070800, 080000 (EDGE_MODE=0); line_done single pulse with the 8th read; next cycle data_in_ready=1, fill_count=0.
REQ-032 EDGE_MODE=1, same line -> last two windows 070808 and 080808.
REQ-033 data_in_valid held high during DRAIN with pixel 0xFF -> no window change, fill_count stays 8; data_out_read during FILL -> rc stays 0.
REQ-034 Gapped reads (data_out_read toggling) -> window holds between reads; exactly 8 read pulses produce one line_done.
REQ-035 Reset asserted after 5 of 8 writes, then pixels 0x11..0x18 written -> first window 0x111213; reset in DRAIN concurrent with data_out_read -> no line_done, data_out_valid=0 next cycle.

Source files
------------

// File: rtl/window_line_buffer_if.sv
// Handshake bundle for the window line buffer.
// The slave side is the buffer itself; the master side is whoever writes
// pixels into it and consumes the windows it produces.
interface window_line_buffer_if #(
   parameter int PIXEL_WIDTH  = 8,
   parameter int KERNEL_WIDTH = 3,
   parameter int IW_BIT_NUM   = 9
);
   logic [PIXEL_WIDTH-1:0]              data_in_pixel;
   logic                                data_in_valid;
   logic                                data_in_ready;
   logic [KERNEL_WIDTH*PIXEL_WIDTH-1:0] data_out_window;
   logic                                data_out_valid;
   logic                                data_out_read;
   logic                                line_done;
   logic [IW_BIT_NUM:0]                 fill_count;

   modport slave (
      input  data_in_pixel,
      input  data_in_valid,
      input  data_out_read,
      output data_in_ready,
      output data_out_window,
      output data_out_valid,
      output line_done,
      output fill_count
   );

   modport master (
      output data_in_pixel,
      output data_in_valid,
      output data_out_read,
      input  data_in_ready,
      input  data_out_window,
      input  data_out_valid,
      input  line_done,
      input  fill_count
   );
endinterface

// File: rtl/window_line_buffer.sv
// Single-line pixel buffer that is written one full image line at a time and
// then read back as a sliding KERNEL_WIDTH-pixel window, one column per read.
//
// state | meaning
// FILL  | accepting pixels, no window available
// DRAIN | line complete, windows presented, writes refused
module window_line_buffer #(
   parameter int IMAGE_WIDTH  = 512,
   parameter int IW_BIT_NUM   = 9,
   parameter int PIXEL_WIDTH  = 8,
   parameter int KERNEL_WIDTH = 3,
   parameter int EDGE_MODE    = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   window_line_buffer_if.slave   bus
);

   localparam int PTR_W = IW_BIT_NUM + 1;
   localparam int DEPTH = 2 ** IW_BIT_NUM;
   localparam logic [IW_BIT_NUM:0]   LAST_COL  = PTR_W'(IMAGE_WIDTH - 1);
   localparam logic [IW_BIT_NUM-1:0] LAST_ADDR = IW_BIT_NUM'(IMAGE_WIDTH - 1);

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t                   state_q, state_d;
   logic [IW_BIT_NUM:0]      wp_q, wp_d;
   logic [IW_BIT_NUM:0]      rc_q, rc_d;
   logic [PIXEL_WIDTH-1:0]   mem_q [DEPTH];

   logic                     wr_en;
   logic                     ready_o;
   logic                     valid_o;
   logic                     line_done_o;
   logic [KERNEL_WIDTH*PIXEL_WIDTH-1:0] window_o;
   logic [IW_BIT_NUM:0]      col_idx;
   logic [PIXEL_WIDTH-1:0]   col_pix;

   // State, write pointer and read column registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FILL;
         wp_q    <= '0;
         rc_q    <= '0;
      end else begin
         state_q <= state_d;
         wp_q    <= wp_d;
         rc_q    <= rc_d;
      end
   end

   // Pixel storage; never cleared, only overwritten by accepted writes.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wp_q[IW_BIT_NUM-1:0]] <= bus.data_in_pixel;
      end
   end

   // Next-state logic and handshake outputs. Reset blocks both the write and
   // the read so a reset cycle never stores a pixel nor reports line_done.
   always_comb begin
      state_d     = state_q;
      wp_d        = wp_q;
      rc_d        = rc_q;
      wr_en       = 1'b0;
      ready_o     = 1'b0;
      valid_o     = 1'b0;
      line_done_o = 1'b0;
      case (state_q)
         FILL: begin
            ready_o = 1'b1;
            if (bus.data_in_valid && !reset) begin
               wr_en = 1'b1;
               wp_d  = wp_q + 1'b1;
               if (wp_q == LAST_COL) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            valid_o = 1'b1;
            if (bus.data_out_read && !reset) begin
               if (rc_q == LAST_COL) begin
                  line_done_o = 1'b1;
                  rc_d        = '0;
                  wp_d        = '0;
                  state_d     = FILL;
               end else begin
                  rc_d = rc_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   // Window assembly: element 0 lands in the MSBs. Columns past the line end
   // are padded rather than wrapped; the column index carries one extra bit
   // so rc + i cannot overflow before the comparison.
   always_comb begin
      window_o = '0;
      col_idx  = '0;
      col_pix  = '0;
      for (int i = 0; i < KERNEL_WIDTH; i++) begin
         col_idx = rc_q + PTR_W'(i);
         if (col_idx <= LAST_COL) begin
            col_pix = mem_q[col_idx[IW_BIT_NUM-1:0]];
         end else if (EDGE_MODE == 1) begin
            col_pix = mem_q[LAST_ADDR];
         end else begin
            col_pix = '0;
         end
         window_o[(KERNEL_WIDTH-1-i)*PIXEL_WIDTH +: PIXEL_WIDTH] = col_pix;
      end
   end

   assign bus.data_in_ready   = ready_o;
   assign bus.data_out_valid  = valid_o;
   assign bus.line_done       = line_done_o;
   assign bus.data_out_window = window_o;
   assign bus.fill_count      = wp_q;

endmodule

// File: tb/tb_window_line_buffer.sv
// Directed bench for window_line_buffer: two instances (zero pad and
// replicate edge) share one stimulus stream; IMAGE_WIDTH=8, K=3.
module tb_window_line_buffer;

   logic       clk = 1'b0;
   logic       rst;
   logic       vin;
   logic [7:0] pix;
   logic       rd;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   window_line_buffer_if #(.PIXEL_WIDTH(8), .KERNEL_WIDTH(3), .IW_BIT_NUM(3)) if0 ();
   window_line_buffer_if #(.PIXEL_WIDTH(8), .KERNEL_WIDTH(3), .IW_BIT_NUM(3)) if1 ();

   assign if0.data_in_pixel = pix;
   assign if0.data_in_valid = vin;
   assign if0.data_out_read = rd;
   assign if1.data_in_pixel = pix;
   assign if1.data_in_valid = vin;
   assign if1.data_out_read = rd;

   window_line_buffer #(
      .IMAGE_WIDTH(8), .IW_BIT_NUM(3), .PIXEL_WIDTH(8), .KERNEL_WIDTH(3), .EDGE_MODE(0)
   ) dut0 (
      .clk   (clk),
      .reset (rst),
      .bus   (if0.slave)
   );

   window_line_buffer #(
      .IMAGE_WIDTH(8), .IW_BIT_NUM(3), .PIXEL_WIDTH(8), .KERNEL_WIDTH(3), .EDGE_MODE(1)
   ) dut1 (
      .clk   (clk),
      .reset (rst),
      .bus   (if1.slave)
   );

   typedef struct {
      logic        rst;
      logic        vin;
      logic [7:0]  pix;
      logic        rd;
      logic        exp_ready;
      logic        exp_valid;
      logic        exp_ld;
      logic [3:0]  exp_fill;
      logic        chk_win;
      logic [23:0] exp_win0;
      logic [23:0] exp_win1;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic v, input logic [7:0] p, input logic d,
                               input logic er, input logic ev, input logic el, input logic [3:0] ef,
                               input logic cw, input logic [23:0] w0, input logic [23:0] w1);
      vec_t t;
      t.rst = r; t.vin = v; t.pix = p; t.rd = d;
      t.exp_ready = er; t.exp_valid = ev; t.exp_ld = el; t.exp_fill = ef;
      t.chk_win = cw; t.exp_win0 = w0; t.exp_win1 = w1;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic drive(input logic r, input logic v, input logic [7:0] p, input logic d);
      rst = r; vin = v; pix = p; rd = d;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t t, input int k);
      drive(t.rst, t.vin, t.pix, t.rd);
      @(negedge clk);
      chk($sformatf("v%0d ready", k), 32'(if0.data_in_ready), 32'(t.exp_ready));
      chk($sformatf("v%0d valid0", k), 32'(if0.data_out_valid), 32'(t.exp_valid));
      chk($sformatf("v%0d valid1", k), 32'(if1.data_out_valid), 32'(t.exp_valid));
      chk($sformatf("v%0d line_done", k), 32'(if0.line_done), 32'(t.exp_ld));
      chk($sformatf("v%0d fill", k), 32'(if0.fill_count), 32'(t.exp_fill));
      if (t.chk_win) begin
         chk($sformatf("v%0d win_zero", k), 32'(if0.data_out_window), 32'(t.exp_win0));
         chk($sformatf("v%0d win_repl", k), 32'(if1.data_out_window), 32'(t.exp_win1));
      end
      next_cycle();
   endtask

   initial begin
      // Line 1: pixels 1..8, then drain with writes of 0xFF attempted and gapped reads.
      for (int k = 0; k < 8; k++)
         tbl.push_back(mk(0, 1, 8'(k + 1), 0, 1, 0, 0, 4'(k), 0, 24'h0, 24'h0));
      tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 1, 0, 4'd8, 1, 24'h010203, 24'h010203));
      tbl.push_back(mk(0, 1, 8'hFF, 1, 0, 1, 0, 4'd8, 1, 24'h010203, 24'h010203));
      tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 1, 0, 4'd8, 1, 24'h020304, 24'h020304));
      tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 1, 0, 4'd8, 1, 24'h020304, 24'h020304));
      tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 4'd8, 1, 24'h020304, 24'h020304));
      tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 4'd8, 1, 24'h030405, 24'h030405));
      tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 4'd8, 1, 24'h040506, 24'h040506));
      tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 4'd8, 1, 24'h040506, 24'h040506));
      tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 4'd8, 1, 24'h050607, 24'h050607));
      tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 4'd8, 1, 24'h060708, 24'h060708));
      tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 4'd8, 1, 24'h070800, 24'h070808));
      tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 4'd8, 1, 24'h070800, 24'h070808));
      tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 1, 4'd8, 1, 24'h080000, 24'h080808));
      // Back in FILL: reads ignored, rc must stay 0.
      tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 4'd0, 0, 24'h0, 24'h0));
      tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 4'd0, 0, 24'h0, 24'h0));
      // Line 2: 0x21..0x28 with an idle gap after the third pixel.
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(0, 1, 8'(8'h21 + k), 1, 1, 0, 0, 4'(k), 0, 24'h0, 24'h0));
      tbl.push_back(mk(0, 0, 8'h77, 0, 1, 0, 0, 4'd3, 0, 24'h0, 24'h0));
      for (int k = 3; k < 8; k++)
         tbl.push_back(mk(0, 1, 8'(8'h21 + k), 0, 1, 0, 0, 4'(k), 0, 24'h0, 24'h0));
      tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 4'd8, 1, 24'h212223, 24'h212223));

      // Initial reset and post-reset state.
      drive(1, 1, 8'h55, 1);
      next_cycle();
      next_cycle();
      drive(0, 0, 8'h00, 0);
      @(negedge clk);
      chk("reset ready", 32'(if0.data_in_ready), 32'd1);
      chk("reset valid", 32'(if0.data_out_valid), 32'd0);
      chk("reset line_done", 32'(if0.line_done), 32'd0);
      chk("reset fill", 32'(if0.fill_count), 32'd0);
      next_cycle();

      for (int k = 0; k < tbl.size(); k++) run_vec(tbl[k], k);

      // Reset in DRAIN at rc=0 together with a read: drops back to FILL.
      drive(1, 0, 8'h00, 1);
      @(negedge clk);
      chk("rst_drain0 line_done", 32'(if0.line_done), 32'd0);
      next_cycle();
      drive(0, 0, 8'h00, 0);
      @(negedge clk);
      chk("rst_drain0 valid", 32'(if0.data_out_valid), 32'd0);
      chk("rst_drain0 ready", 32'(if0.data_in_ready), 32'd1);
      chk("rst_drain0 fill", 32'(if0.fill_count), 32'd0);
      next_cycle();

      // Reset after 5 of 8 writes; the reset cycle also carries a write that must be dropped.
      for (int k = 0; k < 5; k++) begin
         drive(0, 1, 8'(8'hA1 + k), 0);
         next_cycle();
      end
      drive(1, 1, 8'hEE, 0);
      next_cycle();
      drive(0, 0, 8'h00, 0);
      @(negedge clk);
      chk("rst_fill fill", 32'(if0.fill_count), 32'd0);
      for (int k = 0; k < 8; k++) begin
         drive(0, 1, 8'(8'h11 + k), 0);
         next_cycle();
      end
      drive(0, 0, 8'h00, 0);
      @(negedge clk);
      chk("rst_fill valid", 32'(if0.data_out_valid), 32'd1);
      chk("rst_fill win_zero", 32'(if0.data_out_window), 32'h111213);
      chk("rst_fill win_repl", 32'(if1.data_out_window), 32'h111213);
      chk("rst_fill count", 32'(if0.fill_count), 32'd8);
      next_cycle();

      // Advance to the last column, then reset concurrently with the final read.
      for (int k = 0; k < 7; k++) begin
         drive(0, 0, 8'h00, 1);
         @(negedge clk);
         chk($sformatf("rd%0d line_done", k), 32'(if0.line_done), 32'd0);
         next_cycle();
      end
      drive(0, 0, 8'h00, 0);
      @(negedge clk);
      chk("last_col win_zero", 32'(if0.data_out_window), 32'h180000);
      chk("last_col win_repl", 32'(if1.data_out_window), 32'h181818);
      drive(1, 0, 8'h00, 1);
      @(negedge clk);
      chk("rst_last line_done", 32'(if0.line_done), 32'd0);
      chk("rst_last line_done1", 32'(if1.line_done), 32'd0);
      next_cycle();
      drive(0, 0, 8'h00, 1);
      @(negedge clk);
      chk("rst_last valid", 32'(if0.data_out_valid), 32'd0);
      chk("rst_last ready", 32'(if0.data_in_ready), 32'd1);
      chk("rst_last fill", 32'(if0.fill_count), 32'd0);
      chk("rst_last line_done_after", 32'(if0.line_done), 32'd0);
      next_cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
